// File: rtl/ask_tx_pkg.sv
// Shared state encoding and default constants for the ASK transmit frame path.
package ask_tx_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StPreamble,
    StSync,
    StPayload,
    StGap
  } ask_state_e;

  localparam int unsigned WordWDefault = 12;
  localparam logic [WordWDefault-1:0] SyncWordDefault = 12'hE2B;
  localparam logic PreambleStartBit = 1'b1;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/ask_bit_timer.sv
// Bit-period divider: bit_tick marks the last clk cycle of each BIT_DIV-cycle period.
module ask_bit_timer #(
  parameter int unsigned BIT_DIV = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic bit_tick,
  output logic bit_tick_next
);

  localparam int unsigned CntW = (BIT_DIV > 1) ? $clog2(BIT_DIV) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(BIT_DIV - 1);
  localparam logic [CntW-1:0] CntPenult = CntW'((BIT_DIV > 1) ? BIT_DIV - 2 : 0);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign bit_tick = en && (cnt_q == CntLast);
  // The following cycle closes a period: used to align pulses that must land on a period end.
  assign bit_tick_next = en && (bit_tick ? (BIT_DIV == 1) : (cnt_q == CntPenult));

  // Held at zero while disabled so each enable starts a fresh period.
  always_comb begin
    cnt_d = '0;
    if (en && !bit_tick) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/ask_frame_ctrl.sv
// ASK frame sequencer: preamble, sync word, prefetched payload words, then a silent guard gap.
module ask_frame_ctrl
  import ask_tx_pkg::*;
#(
  parameter int unsigned       WORD_W        = WordWDefault,
  parameter int unsigned       PREAMBLE_LEN  = 16,
  parameter logic [WORD_W-1:0] SYNC_WORD     = WORD_W'(SyncWordDefault),
  parameter int unsigned       PAYLOAD_WORDS = 4,
  parameter int unsigned       GAP_LEN       = 8,
  parameter int unsigned       BIT_DIV       = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [WORD_W-1:0] word_in,
  input  logic              word_valid,
  output logic              word_ready,
  output logic              lfsr_load,
  output logic              tx_bit,
  output logic              tx_en,
  output logic              busy,
  output logic              frame_done,
  output logic              underrun
);

  localparam int unsigned MaxLen   = max3(PREAMBLE_LEN, WORD_W, GAP_LEN);
  localparam int unsigned BitCntW  = (MaxLen > 1) ? $clog2(MaxLen) : 1;
  localparam int unsigned WordCntW = (PAYLOAD_WORDS > 1) ? $clog2(PAYLOAD_WORDS) : 1;

  localparam logic [BitCntW-1:0]  PreLast  = BitCntW'(PREAMBLE_LEN - 1);
  localparam logic [BitCntW-1:0]  WordLast = BitCntW'(WORD_W - 1);
  localparam logic [BitCntW-1:0]  GapLast  = BitCntW'(GAP_LEN - 1);
  localparam logic [WordCntW-1:0] LastWord = WordCntW'(PAYLOAD_WORDS - 1);

  ask_state_e          state_q, state_d;
  logic [BitCntW-1:0]  bit_cnt_q, bit_cnt_d;
  logic [WordCntW-1:0] word_cnt_q, word_cnt_d;
  logic [WORD_W-1:0]   shreg_q, shreg_d;
  logic [WORD_W-1:0]   pre_word_q, pre_word_d;
  logic                pre_valid_q, pre_valid_d;
  logic                word_ready_q, word_ready_d;
  logic                lfsr_load_q, lfsr_load_d;
  logic                tx_bit_q, tx_bit_d;
  logic                tx_en_q, tx_en_d;
  logic                busy_q, busy_d;
  logic                frame_done_q, frame_done_d;
  logic                underrun_q, underrun_d;

  logic              timer_en, bit_tick, bit_tick_next;
  logic              xfer, word_avail;
  logic [WORD_W-1:0] next_word;

  assign timer_en = (state_q != StIdle);

  ask_bit_timer #(
    .BIT_DIV(BIT_DIV)
  ) u_bit_timer (
    .clk          (clk),
    .rst          (rst),
    .en           (timer_en),
    .bit_tick     (bit_tick),
    .bit_tick_next(bit_tick_next)
  );

  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    word_cnt_d   = word_cnt_q;
    shreg_d      = shreg_q;
    pre_word_d   = pre_word_q;
    pre_valid_d  = pre_valid_q;
    tx_bit_d     = tx_bit_q;
    tx_en_d      = tx_en_q;
    busy_d       = busy_q;
    lfsr_load_d  = 1'b0;
    underrun_d   = 1'b0;
    frame_done_d = 1'b0;

    xfer       = word_valid && word_ready_q;
    // A word accepted in the last cycle of the window is used directly, bypassing prefetch.
    word_avail = pre_valid_q || xfer;
    next_word  = pre_valid_q ? pre_word_q : word_in;
    if (xfer) begin
      pre_valid_d = 1'b1;
      pre_word_d  = word_in;
    end

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d     = StPreamble;
          bit_cnt_d   = '0;
          word_cnt_d  = '0;
          pre_valid_d = 1'b0;
          tx_bit_d    = PreambleStartBit;
          tx_en_d     = 1'b1;
          busy_d      = 1'b1;
          lfsr_load_d = 1'b1;
        end
      end
      StPreamble: begin
        if (bit_tick) begin
          if (bit_cnt_q == PreLast) begin
            state_d               = StSync;
            bit_cnt_d             = '0;
            {tx_bit_d, shreg_d}   = {SYNC_WORD, 1'b0};
          end else begin
            bit_cnt_d = bit_cnt_q + BitCntW'(1);
            tx_bit_d  = ~tx_bit_q;
          end
        end
      end
      StSync, StPayload: begin
        if (bit_tick) begin
          if (bit_cnt_q != WordLast) begin
            bit_cnt_d           = bit_cnt_q + BitCntW'(1);
            {tx_bit_d, shreg_d} = {shreg_q, 1'b0};
          end else if (state_q == StPayload && word_cnt_q == LastWord) begin
            state_d   = StGap;
            bit_cnt_d = '0;
            tx_en_d   = 1'b0;
            tx_bit_d  = 1'b0;
          end else if (word_avail) begin
            state_d             = StPayload;
            word_cnt_d          = (state_q == StSync) ? '0 : word_cnt_q + WordCntW'(1);
            bit_cnt_d           = '0;
            {tx_bit_d, shreg_d} = {next_word, 1'b0};
            pre_valid_d         = 1'b0;
          end else begin
            state_d    = StGap;
            bit_cnt_d  = '0;
            tx_en_d    = 1'b0;
            tx_bit_d   = 1'b0;
            underrun_d = 1'b1;
          end
        end
      end
      StGap: begin
        if (bit_tick) begin
          if (bit_cnt_q == GapLast) begin
            state_d = StIdle;
            busy_d  = 1'b0;
          end else begin
            bit_cnt_d = bit_cnt_q + BitCntW'(1);
          end
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Ready spans the final bit of sync and of every payload word that has a successor.
    word_ready_d = ((state_d == StSync) ||
                    (state_d == StPayload && word_cnt_d != LastWord)) &&
                   (bit_cnt_d == WordLast) && !pre_valid_d;
    frame_done_d = (state_d == StGap) && (bit_cnt_d == GapLast) && bit_tick_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      bit_cnt_q    <= '0;
      word_cnt_q   <= '0;
      shreg_q      <= '0;
      pre_word_q   <= '0;
      pre_valid_q  <= 1'b0;
      word_ready_q <= 1'b0;
      lfsr_load_q  <= 1'b0;
      tx_bit_q     <= 1'b0;
      tx_en_q      <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      underrun_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      word_cnt_q   <= word_cnt_d;
      shreg_q      <= shreg_d;
      pre_word_q   <= pre_word_d;
      pre_valid_q  <= pre_valid_d;
      word_ready_q <= word_ready_d;
      lfsr_load_q  <= lfsr_load_d;
      tx_bit_q     <= tx_bit_d;
      tx_en_q      <= tx_en_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      underrun_q   <= underrun_d;
    end
  end

  assign word_ready = word_ready_q;
  assign lfsr_load  = lfsr_load_q;
  assign tx_bit     = tx_bit_q;
  assign tx_en      = tx_en_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;
  assign underrun   = underrun_q;

endmodule

// File: doc/ask_frame_ctrl.md
Name: ask_frame_ctrl

Overview:
Frame sequencer for the ASK transmit path. It builds one on-air frame per start request: an alternating preamble, a fixed sync word, PAYLOAD_WORDS payload words pulled from the word generator over a ready/valid handshake, then a silent guard gap. It drives the serial bit and carrier-enable into the ASK modulator output stage. It also pulses the LFSR reseed at each frame start, so every frame's payload is reproducible.

Parameters:
WORD_W, 12, payload/sync word width in bits
PREAMBLE_LEN, 16, preamble length in bit periods (pattern 1,0,1,0,... starting with 1)
SYNC_WORD, 12'hE2B, sync pattern, WORD_W bits, sent MSB first
PAYLOAD_WORDS, 4, words per frame (>=1)
GAP_LEN, 8, guard gap in bit periods after the frame
BIT_DIV, 1, clk cycles per bit period (>=1)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
start  in  1  frame request; sampled only in IDLE
word_in  in  WORD_W  payload word from generator
word_valid  in  1  word_in valid
word_ready  out  1  controller accepts word_in this cycle
lfsr_load  out  1  one-cycle reseed pulse to LFSR
tx_bit  out  1  serial bit to modulator
tx_en  out  1  carrier enable (high for preamble/sync/payload only)
busy  out  1  high from frame start through end of gap
frame_done  out  1  one-cycle pulse at end of gap
underrun  out  1  one-cycle pulse when a payload word was not available

Behaviour:
- Reset (async, immediate): state IDLE; all outputs 0; counters and shift register cleared.
- All outputs registered. A bit period is BIT_DIV clk cycles; bit_tick marks the final cycle of each period.
- States: IDLE, PREAMBLE, SYNC, PAYLOAD, GAP.
- IDLE: start=1 in cycle N -> cycle N+1: state PREAMBLE, busy=1, tx_en=1, tx_bit=1, lfsr_load=1 for exactly that cycle. start=0 -> stay.
- PREAMBLE: PREAMBLE_LEN bit periods, tx_bit alternates starting at 1. After the last period -> SYNC.
- SYNC: SYNC_WORD shifted out MSB first, WORD_W periods -> PAYLOAD.
- PAYLOAD: each accepted word is shifted out MSB first, WORD_W periods per word. Word counter counts 0..PAYLOAD_WORDS-1; after the last word -> GAP.
- Prefetch handshake: word_ready=1 throughout the final bit period of SYNC and of every payload word except the last. A transfer occurs on word_valid&&word_ready. The word is held in a prefetch register and word_ready drops the cycle after acceptance. There is no bubble between words.
- Underrun: if no transfer has occurred by the last cycle of the window, the next cycle has underrun=1 for 1 cycle, tx_en=0 and tx_bit=0, state goes to GAP (full GAP_LEN), and the frame counts as aborted. frame_done still pulses at the end of the gap.
- Words offered with word_ready=0 are ignored and not consumed.
- GAP: tx_en=0, tx_bit=0, busy=1 for GAP_LEN periods. In the final cycle of the gap frame_done=1; the next cycle is IDLE with busy=0.
- start while busy=1 is ignored and not queued. start in the first IDLE cycle after frame_done is accepted (back-to-back frames are legal).
- Frame on-air length = PREAMBLE_LEN+WORD_W*(1+PAYLOAD_WORDS) bit periods (defaults: 76 periods).
- Reset asserted mid-frame: outputs go to 0 immediately. No frame_done or underrun is emitted. Operation resumes in IDLE after release.
- Counters are sized $clog2 of their maximum+1. Counters do not wrap: each is cleared on every state entry.

Decomposition:
- Package ask_tx_pkg holds the state enum (IDLE, PREAMBLE, SYNC, PAYLOAD, GAP), WORD_W default, the SYNC_WORD default and the preamble start polarity constant.
- Sub-module ask_bit_timer(clk, rst, en, bit_tick) is a BIT_DIV divider. It restarts on en rising and sets bit period boundaries.
- The FSM, shift register, prefetch register and counters live in ask_frame_ctrl.

Test Plan:
- Defaults; pulse start; the generator always has valid words A5C,3F0,0F1,FFF -> exactly 76 cycles of tx_en=1. Bits: 1010...(16), E2B MSB first, then A5C,3F0,0F1,FFF MSB first. lfsr_load pulses on the first tx_en cycle. The 8-cycle gap follows, frame_done pulses on gap cycle 8, and busy falls the next cycle.
- word_valid held low for the second payload word -> underrun pulse the cycle after the last bit of word 1. tx_en drops with it, the 8-cycle gap follows, then frame_done. Only one word is consumed.
- start held high through an entire frame -> exactly two frames back-to-back. The second starts one cycle after frame_done. Pulses on start while busy produce no extra frames.
- Assert rst at cycle 40 of a frame -> all outputs 0 in the same cycle. After release, IDLE is entered with no frame_done. A new start then produces a full, correct frame.
- BIT_DIV=3 -> each bit is held 3 cycles and tx_en is high for 228 cycles. word_ready windows are 3 cycles; word_valid asserted in window cycle 2 is accepted with no underrun.
- PAYLOAD_WORDS=1 -> word_ready opens only during the last SYNC bit. tx_en length is 40 periods. word_ready never asserts during payload.
